// File: rtl/image_pkg.sv
// Shared types for the image decimator: pass mode, FSM state and a width helper.
package image_pkg;

  typedef enum logic {
    SUBSAMPLE = 1'b0,
    AVERAGE   = 1'b1
  } decimate_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } decimate_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_decimate_if.sv
// Source-read / destination-write bus of the image decimator.
interface image_decimate_if #(
  parameter int BIT_DEPTH = 8,
  parameter int RD_AW     = 12,
  parameter int WR_AW     = 10
);
  // Valid-only protocol, no back-pressure: ext_read_addr is a request in every
  // cycle ext_read_addr_valid is high and its data arrives on ext_pixel_in a
  // fixed READ_LATENCY cycles later; ext_write_addr/ext_pixel_out form one
  // write in every cycle ext_write_valid is high and must be taken that cycle.
  logic [RD_AW-1:0]     ext_read_addr;
  logic                 ext_read_addr_valid;
  logic [BIT_DEPTH-1:0] ext_pixel_in;
  logic [WR_AW-1:0]     ext_write_addr;
  logic                 ext_write_valid;
  logic [BIT_DEPTH-1:0] ext_pixel_out;

  modport master (
    output ext_read_addr, ext_read_addr_valid,
    input  ext_pixel_in,
    output ext_write_addr, ext_write_valid, ext_pixel_out
  );

  modport slave (
    input  ext_read_addr, ext_read_addr_valid,
    output ext_pixel_in,
    input  ext_write_addr, ext_write_valid, ext_pixel_out
  );
endinterface

// File: rtl/image_decimate_accum.sv
// Row accumulator, line buffer and output divide for the decimator.
// IMAGE_DECIMATE_ROUND_EN selects round-half-up instead of truncating averages.
module image_decimate_accum
  import image_pkg::*;
#(
  parameter int BIT_DEPTH   = 8,
  parameter int OLD_WIDTH   = 64,
  parameter int FACTOR_LOG2 = 1,
  parameter int XW          = 6,
  parameter int YW          = 6,
  parameter int WAW         = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 pix_valid,
  input  logic [XW-1:0]        pix_x,
  input  logic [YW-1:0]        pix_y,
  input  logic [BIT_DEPTH-1:0] pixel,
  input  decimate_mode_t       mode,
  output logic                 wr_valid,
  output logic [WAW-1:0]       wr_addr,
  output logic [BIT_DEPTH-1:0] wr_data
);
  localparam int F         = 1 << FACTOR_LOG2;
  localparam int NEW_WIDTH = OLD_WIDTH / F;
  localparam int RW        = BIT_DEPTH + FACTOR_LOG2;
  localparam int SW        = BIT_DEPTH + 2 * FACTOR_LOG2;
  localparam int LBW       = clog2_min1(NEW_WIDTH);
  localparam logic [FACTOR_LOG2-1:0] PH_LAST = '1;

  logic [FACTOR_LOG2-1:0] x_ph, y_ph;
  logic [XW-1:0]          bx;
  logic [YW-1:0]          by;
  logic [LBW-1:0]         lb_idx;
  logic [RW-1:0]          row_acc, row_sum;
  logic [SW-1:0]          lb [NEW_WIDTH];
  logic [SW-1:0]          lb_prev, block_sum, rounded;
  logic                   fire;
  logic [BIT_DEPTH-1:0]   out_val;
  logic [WAW-1:0]         out_addr;

  assign x_ph   = pix_x[FACTOR_LOG2-1:0];
  assign y_ph   = pix_y[FACTOR_LOG2-1:0];
  assign bx     = pix_x >> FACTOR_LOG2;
  assign by     = pix_y >> FACTOR_LOG2;
  assign lb_idx = LBW'(bx);

  // The first pixel of a row segment and the first row of a block band start
  // fresh, so stale line-buffer contents never reach an output.
  assign row_sum   = ((x_ph == '0) ? '0 : row_acc) + RW'(pixel);
  assign lb_prev   = (y_ph == '0) ? '0 : lb[lb_idx];
  assign block_sum = lb_prev + SW'(row_sum);

`ifdef IMAGE_DECIMATE_ROUND_EN
  localparam logic [SW-1:0] HALF = SW'(1) << (2 * FACTOR_LOG2 - 1);
  assign rounded = block_sum + HALF;
`else
  assign rounded = block_sum;
`endif

  always_comb begin
    fire     = 1'b0;
    out_val  = '0;
    out_addr = WAW'(int'(by) * NEW_WIDTH + int'(bx));
    if (mode == SUBSAMPLE) begin
      fire    = pix_valid && (x_ph == '0) && (y_ph == '0);
      out_val = pixel;
    end else begin
      fire    = pix_valid && (x_ph == PH_LAST) && (y_ph == PH_LAST);
      out_val = BIT_DEPTH'(rounded >> (2 * FACTOR_LOG2));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_acc <= '0;
    end else if (pix_valid) begin
      row_acc <= row_sum;
    end
  end

  always_ff @(posedge clk_in) begin
    if (pix_valid && (x_ph == PH_LAST)) begin
      lb[lb_idx] <= block_sum;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= fire;
      if (fire) begin
        wr_addr <= out_addr;
        wr_data <= out_val;
      end
    end
  end

endmodule

// File: rtl/image_decimate.sv
// Image decimator top: pass FSM, raster read counters and read-latency tag pipe.
// IMAGE_DECIMATE_ROUND_EN (see image_decimate_accum) enables rounded averages.
module image_decimate
  import image_pkg::*;
#(
  parameter int BIT_DEPTH    = 8,
  parameter int OLD_WIDTH    = 64,
  parameter int OLD_HEIGHT   = 64,
  parameter int FACTOR_LOG2  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             mode_in,
  image_decimate_if.master bus,
  output logic             busy_out,
  output logic             done_out,
  output decimate_state_t  state_dbg
);
  localparam int F          = 1 << FACTOR_LOG2;
  localparam int NEW_WIDTH  = OLD_WIDTH / F;
  localparam int NEW_HEIGHT = OLD_HEIGHT / F;
  localparam int XW         = clog2_min1(OLD_WIDTH);
  localparam int YW         = clog2_min1(OLD_HEIGHT);
  localparam int RAW        = clog2_min1(OLD_WIDTH * OLD_HEIGHT);
  localparam int WAW        = clog2_min1(NEW_WIDTH * NEW_HEIGHT);
  localparam int DW         = clog2_min1(READ_LATENCY + 2);
  localparam logic [XW-1:0] X_LAST     = XW'(OLD_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(OLD_HEIGHT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(READ_LATENCY);

  decimate_state_t state, state_nxt;
  decimate_mode_t  mode_q;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [RAW-1:0]  rd_addr;
  logic [DW-1:0]   drain_cnt;
  logic            last_req, rd_valid, accept;

  logic [READ_LATENCY-1:0] pipe_v;
  logic [XW-1:0]           pipe_x [READ_LATENCY];
  logic [YW-1:0]           pipe_y [READ_LATENCY];

  assign last_req = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign accept   = (state == IDLE) && start_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // DRAIN lasts READ_LATENCY+1 cycles: the last data return plus its write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_in) state_nxt = READ;
      READ:    if (last_req) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_valid = (state == READ);
    busy_out = (state != IDLE);
    done_out = (state == DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      mode_q    <= SUBSAMPLE;
    end else begin
      if (accept) begin
        x_cnt   <= '0;
        y_cnt   <= '0;
        rd_addr <= '0;
        mode_q  <= mode_in ? AVERAGE : SUBSAMPLE;
      end else if (rd_valid) begin
        rd_addr <= last_req ? '0 : rd_addr + 1'b1;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // Tag each request with its coordinates so the tail stage lines up with
  // the data the source returns READ_LATENCY cycles later.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_valid;
      pipe_x[0] <= x_cnt;
      pipe_y[0] <= y_cnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end

  assign bus.ext_read_addr       = rd_addr;
  assign bus.ext_read_addr_valid = rd_valid;
  assign state_dbg               = state;

  image_decimate_accum #(
    .BIT_DEPTH   (BIT_DEPTH),
    .OLD_WIDTH   (OLD_WIDTH),
    .FACTOR_LOG2 (FACTOR_LOG2),
    .XW          (XW),
    .YW          (YW),
    .WAW         (WAW)
  ) u_accum (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pix_valid (pipe_v[READ_LATENCY-1]),
    .pix_x     (pipe_x[READ_LATENCY-1]),
    .pix_y     (pipe_y[READ_LATENCY-1]),
    .pixel     (bus.ext_pixel_in),
    .mode      (mode_q),
    .wr_valid  (bus.ext_write_valid),
    .wr_addr   (bus.ext_write_addr),
    .wr_data   (bus.ext_pixel_out)
  );

endmodule

// File: doc/image_decimate.md
IMAGE_DECIMATE -- requirements
Module: image_decimate

Interface
REQ-001 Parameter BIT_DEPTH, default 8, pixel width in bits.
REQ-002 Parameter OLD_WIDTH, default 64, source width in pixels, SHALL be a multiple of 2^FACTOR_LOG2.
REQ-003 Parameter OLD_HEIGHT, default 64, source height in pixels, SHALL be a multiple of 2^FACTOR_LOG2.
REQ-004 Parameter FACTOR_LOG2, default 1, range 1..3, decimation factor F=2^FACTOR_LOG2 per axis.
REQ-005 Parameter READ_LATENCY, default 2, source-BRAM address-to-data latency in cycles.
REQ-006 clk_in  input  1  sole clock; all logic on rising edge.
REQ-007 rst_in  input  1  asynchronous, active-high reset.
REQ-008 start_in  input  1  one-cycle pulse starting a pass.
REQ-009 mode_in  input  1  0=subsample (top-left pixel of each FxF block), 1=box average; sampled with start_in.
REQ-010 ext_read_addr  output  clog2(OLD_WIDTH*OLD_HEIGHT)  raster source address.
REQ-011 ext_read_addr_valid  output  1  ext_read_addr is a live request this cycle.
REQ-012 ext_pixel_in  input  BIT_DEPTH  source data, READ_LATENCY cycles after its request.
REQ-013 ext_write_addr  output  clog2(NEW_WIDTH*NEW_HEIGHT)  destination address, NEW_WIDTH=OLD_WIDTH/F, NEW_HEIGHT=OLD_HEIGHT/F.
REQ-014 ext_write_valid  output  1  write strobe.
REQ-015 ext_pixel_out  output  BIT_DEPTH  destination pixel.
REQ-016 busy_out  output  1  high from cycle after accepted start_in through done_out cycle.
REQ-017 done_out  output  1  one-cycle pulse when a pass completes.

Function
REQ-018 FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on start_in; READ->DRAIN after last request issued; DRAIN->DONE after READ_LATENCY+1 cycles; DONE->IDLE after one cycle.
REQ-019 start_in SHALL be accepted only in IDLE; start_in in any other state is ignored with no effect.
REQ-020 In READ one request per cycle, raster order x fastest, address = y*OLD_WIDTH+x, first request the cycle after start_in, OLD_WIDTH*OLD_HEIGHT requests without gaps.
REQ-021 Returned data SHALL be tagged with its (x,y) via a READ_LATENCY-deep valid/coordinate delay pipe.
REQ-022 Subsample: a write SHALL occur for each pixel with x%F==0 and y%F==0, value = pixel, addr = (y/F)*NEW_WIDTH + x/F.
REQ-023 Average: row partial sums of F pixels SHALL accumulate into a NEW_WIDTH-entry line buffer of width BIT_DEPTH+2*FACTOR_LOG2 bits; entry is overwritten (not added) when y%F==0.
REQ-024 Average: on pixel x%F==F-1, y%F==F-1, output = full block sum >> 2*FACTOR_LOG2 (see REQ-033), addr = (y/F)*NEW_WIDTH + x/F; no overflow for any input.
REQ-025 ext_write_valid SHALL rise exactly 1 cycle after the triggering pixel is present on ext_pixel_in; one-cycle pulse per output pixel; exactly NEW_WIDTH*NEW_HEIGHT writes per pass, strictly increasing addresses.
REQ-026 done_out SHALL pulse the cycle after the final write; pass length start_in->done_out = OLD_WIDTH*OLD_HEIGHT+READ_LATENCY+2 cycles.
REQ-027 Counters wrap x at OLD_WIDTH-1 to 0 with y+1; after y=OLD_HEIGHT-1, x=OLD_WIDTH-1 counters return to 0.
REQ-028 mode_in changes during a pass SHALL not affect that pass.

Reset
REQ-029 On rst_in, immediately: state IDLE, counters 0, delay pipe invalid, all outputs 0 (addresses, valids, pixel_out, busy_out, done_out).
REQ-030 Reset mid-pass SHALL abort with no further writes or done_out; next start_in runs a full clean pass.
REQ-031 Line buffer contents need not be reset; correctness SHALL not depend on them.

Configuration
REQ-032 Macro IMAGE_DECIMATE_ROUND_EN selects averaging rounding.
REQ-033 Defined: output = (sum + 2^(2*FACTOR_LOG2-1)) >> 2*FACTOR_LOG2 (round half up, saturate not needed); undefined: truncation. Subsample mode unaffected.

Structure
REQ-034 Shared package image_pkg SHALL hold decimate_mode_t (SUBSAMPLE, AVERAGE) and decimate_state_t enums.
REQ-035 Sub-module image_decimate_accum SHALL hold row accumulator, line buffer and output divide; top holds FSM, address counters, delay pipe.

Verification
REQ-036 8x8, F=2, subsample, pixel=addr -> 16 writes; addr0=0, addr1=2, addr4=16, addr15=54.
REQ-037 8x8, F=2, average, pixel=addr, no ROUND_EN -> out[0]=4 ((0+1+8+9)/4); with ROUND_EN -> out[0]=5.
REQ-038 16x16, F=4, average, all pixels 255 -> 16 writes all 255, no wrap.
REQ-039 8x8, F=2, start_in re-pulsed at cycle 10 -> ignored; done_out exactly at cycle 64+READ_LATENCY+2 after first start_in.
REQ-040 rst_in asserted mid-pass at cycle 20 -> outputs 0 same cycle, no done_out; restart -> full correct 16-write pass.
